// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed byte stream, writes 16-bit words into
// instruction memory and releases the processor once the checksum matches.
module imem_loader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              load_req,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  state_t      state;
  state_t      next_state;
  logic [7:0]  len_hi;
  logic [7:0]  data_hi;
  logic [7:0]  csum;
  logic [15:0] word_count;
  logic [15:0] word_idx;
  logic [15:0] len_n;
  logic        accept;

  assign rx_ready = (state != S_DONE) && (state != S_ERROR);
  assign accept   = rx_valid && rx_ready;
  assign len_n    = {len_hi, rx_data};

  // Next state is resolved here so the status outputs can be registered
  // against the state being entered rather than lagging it by a cycle.
  always_comb begin
    next_state = state;
    case (state)
      S_LEN_HI:  if (accept) next_state = S_LEN_LO;
      S_LEN_LO: begin
        if (accept) begin
          if (len_n == 16'd0)             next_state = S_CSUM;
          else if ({1'b0, len_n} > MAX_N) next_state = S_ERROR;
          else                            next_state = S_DATA_HI;
        end
      end
      S_DATA_HI: if (accept) next_state = S_DATA_LO;
      S_DATA_LO: begin
        if (accept)
          next_state = ((word_idx + 16'd1) == word_count) ? S_CSUM : S_DATA_HI;
      end
      S_CSUM: begin
        if (accept) next_state = (rx_data == csum) ? S_DONE : S_ERROR;
      end
      S_DONE, S_ERROR: if (load_req) next_state = S_LEN_HI;
      default: next_state = S_LEN_HI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_LEN_HI;
      len_hi     <= '0;
      data_hi    <= '0;
      csum       <= '0;
      word_count <= '0;
      word_idx   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
      cpu_reset  <= 1'b1;
    end else begin
      state     <= next_state;
      done      <= (next_state == S_DONE);
      error     <= (next_state == S_ERROR);
      cpu_reset <= (next_state != S_DONE);
      imem_we   <= 1'b0;

      if (accept) begin
        case (state)
          S_LEN_HI: len_hi <= rx_data;
          S_LEN_LO: word_count <= len_n;
          S_DATA_HI: begin
            data_hi <= rx_data;
            csum    <= csum + rx_data;
          end
          S_DATA_LO: begin
            imem_we    <= 1'b1;
            imem_addr  <= word_idx[ADDR_W-1:0];
            imem_wdata <= {data_hi, rx_data};
            word_idx   <= word_idx + 16'd1;
            csum       <= csum + rx_data;
          end
          default: ;
        endcase
      end

      // A restart keeps memory contents but forgets all progress counters.
      if ((state == S_DONE || state == S_ERROR) && load_req) begin
        word_idx   <= '0;
        csum       <= '0;
        word_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a byte-position model of the stream
// format is compared against the DUT every cycle, plus literal end checks.
module tb_imem_loader;

  localparam int ADDR_W    = 10;
  localparam int MAX_WORDS = 1024;
  localparam int LOADING   = 0;
  localparam int ST_DONE   = 1;
  localparam int ST_ERROR  = 2;

  logic              clk      = 1'b0;
  logic              reset    = 1'b1;
  logic [7:0]        rx_data  = 8'h00;
  logic              rx_valid = 1'b0;
  logic              load_req = 1'b0;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  logic              cpu_reset;
  logic              done;
  logic              error;

  int total = 0;
  int bad   = 0;

  int                m_status = LOADING;
  int                m_pos    = 0;
  int                m_n      = 0;
  int                m_k      = 0;
  logic [7:0]        m_sum    = 8'h00;
  logic [7:0]        m_hi     = 8'h00;
  logic [7:0]        m_dhi    = 8'h00;
  logic              m_we     = 1'b0;
  logic [ADDR_W-1:0] m_addr   = '0;
  logic [15:0]       m_data   = '0;
  bit                armed    = 1'b0;
  logic [31:0]       wlog[$];

  imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .load_req   (load_req),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Stream model: tracks the byte position within the image rather than
  // any loader state, and derives writes and status from that position.
  always @(posedge clk) begin
    m_we = 1'b0;
    if (reset) begin
      armed    = 1'b1;
      m_status = LOADING;
      m_pos    = 0;
      m_n      = 0;
      m_sum    = 8'h00;
      m_addr   = '0;
      m_data   = '0;
    end else if (m_status == LOADING) begin
      if (rx_valid) begin
        if (m_pos == 0) begin
          m_hi  = rx_data;
          m_pos = 1;
        end else if (m_pos == 1) begin
          m_n = int'({m_hi, rx_data});
          if (m_n > MAX_WORDS) m_status = ST_ERROR;
          else m_pos = 2;
        end else if (m_pos < 2 + 2 * m_n) begin
          m_k   = m_pos - 2;
          m_sum = m_sum + rx_data;
          if (m_k % 2 == 0) m_dhi = rx_data;
          else begin
            m_we   = 1'b1;
            m_addr = ADDR_W'(m_k / 2);
            m_data = {m_dhi, rx_data};
          end
          m_pos++;
        end else begin
          m_status = (rx_data == m_sum) ? ST_DONE : ST_ERROR;
        end
      end
    end else if (load_req) begin
      m_status = LOADING;
      m_pos    = 0;
      m_n      = 0;
      m_sum    = 8'h00;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      checkOutput("rx_ready",   32'(rx_ready),   32'(m_status == LOADING));
      checkOutput("done",       32'(done),       32'(m_status == ST_DONE));
      checkOutput("error",      32'(error),      32'(m_status == ST_ERROR));
      checkOutput("cpu_reset",  32'(cpu_reset),  32'(m_status != ST_DONE));
      checkOutput("imem_we",    32'(imem_we),    32'(m_we));
      checkOutput("imem_addr",  32'(imem_addr),  32'(m_addr));
      checkOutput("imem_wdata", 32'(imem_wdata), 32'(m_data));
      if (imem_we) wlog.push_back({6'd0, imem_addr, imem_wdata});
    end
  end

  task automatic applyStimulus(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #2;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulseLoad();
    load_req = 1'b1;
    @(posedge clk);
    #2;
    load_req = 1'b0;
  endtask

  task automatic checkFlags(input string tag, input logic d, input logic e, input logic c, input logic r);
    checkOutput({tag, "_done"},      32'(done),      32'(d));
    checkOutput({tag, "_error"},     32'(error),     32'(e));
    checkOutput({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(c));
    checkOutput({tag, "_rx_ready"},  32'(rx_ready),  32'(r));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    checkFlags("reset", 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("reset_we",    32'(imem_we),    32'h0);
    checkOutput("reset_addr",  32'(imem_addr),  32'h0);
    checkOutput("reset_wdata", 32'(imem_wdata), 32'h0);

    // Two-word image, good checksum, back-to-back bytes
    wlog.delete();
    applyStimulus(8'h00); applyStimulus(8'h02); applyStimulus(8'h12);
    applyStimulus(8'h34); applyStimulus(8'hAB); applyStimulus(8'hCD);
    applyStimulus(8'hBE);
    idle(2);
    checkOutput("good_nwrites", 32'(wlog.size()), 32'd2);
    checkOutput("good_w0", wlog[0], 32'h0000_1234);
    checkOutput("good_w1", wlog[1], 32'h0001_ABCD);
    checkFlags("good", 1'b1, 1'b0, 1'b0, 1'b0);

    // Restart from DONE, then bad checksum
    pulseLoad();
    checkFlags("reload", 1'b0, 1'b0, 1'b1, 1'b1);
    wlog.delete();
    applyStimulus(8'h00); applyStimulus(8'h02); applyStimulus(8'h12);
    applyStimulus(8'h34); applyStimulus(8'hAB); applyStimulus(8'hCD);
    applyStimulus(8'hBF);
    idle(2);
    checkOutput("badsum_nwrites", 32'(wlog.size()), 32'd2);
    checkOutput("badsum_w1", wlog[1], 32'h0001_ABCD);
    checkFlags("badsum", 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(8'hAA);
    checkFlags("err_ignore", 1'b0, 1'b1, 1'b1, 1'b0);

    // Oversize length: 1025 words
    pulseLoad();
    wlog.delete();
    applyStimulus(8'h04); applyStimulus(8'h01);
    checkFlags("toolong", 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(8'h12); applyStimulus(8'h34);
    idle(2);
    checkOutput("toolong_nwrites", 32'(wlog.size()), 32'd0);

    // Empty image with zero checksum, then with a wrong checksum
    pulseLoad();
    applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'h00);
    idle(1);
    checkFlags("empty_ok", 1'b1, 1'b0, 1'b0, 1'b0);
    pulseLoad();
    applyStimulus(8'h00); applyStimulus(8'h00); applyStimulus(8'h01);
    idle(1);
    checkFlags("empty_bad", 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("empty_nwrites", 32'(wlog.size()), 32'd0);

    // Gapped partial image, reset arriving together with the DATA_LO byte
    pulseLoad();
    applyStimulus(8'h00); idle(3);
    applyStimulus(8'h01); idle(3);
    applyStimulus(8'h12); idle(3);
    rx_data  = 8'h34;
    rx_valid = 1'b1;
    reset    = 1'b1;
    @(posedge clk);
    #2;
    reset    = 1'b0;
    rx_valid = 1'b0;
    checkOutput("midreset_we", 32'(imem_we), 32'h0);
    checkFlags("midreset", 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(8'h00); applyStimulus(8'h01); applyStimulus(8'h12);
    applyStimulus(8'h34); applyStimulus(8'h46);
    idle(2);
    checkOutput("midreset_nwrites", 32'(wlog.size()), 32'd1);
    checkOutput("midreset_w0", wlog[0], 32'h0000_1234);
    checkFlags("midreset_done", 1'b1, 1'b0, 1'b0, 1'b0);

    // Restart from DONE; load_req during loading must be ignored
    pulseLoad();
    checkFlags("reload2", 1'b0, 1'b0, 1'b1, 1'b1);
    wlog.delete();
    applyStimulus(8'h00); applyStimulus(8'h01);
    load_req = 1'b1;
    applyStimulus(8'hFF);
    load_req = 1'b0;
    applyStimulus(8'hFF); applyStimulus(8'hFE);
    idle(2);
    checkOutput("ffff_nwrites", 32'(wlog.size()), 32'd1);
    checkOutput("ffff_w0", wlog[0], 32'h0000_FFFF);
    checkFlags("ffff", 1'b1, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
